// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter PUF controller: FSM state encoding,
// arbiter-reset timing, the default LFSR feedback mask and the majority rule.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB_RST = 3'd1,
    LAUNCH  = 3'd2,
    SAMPLE  = 3'd3,
    COMMIT  = 3'd4,
    DONE    = 3'd5
  } puf_state_e;

  // Cycles the arbiter flop is held in reset before each launch.
  localparam int ARB_RST_CYCLES = 2;

  // Default Galois feedback mask for a 16-stage chain.
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

  // A challenge bit is 1 when the ones count is strictly above this value.
  function automatic int majority_threshold(input int n_votes);
    return n_votes / 2;
  endfunction

endpackage

// File: rtl/puf_lfsr.sv
// Right-shifting Galois LFSR that produces the PUF challenge sequence.
// A zero seed is replaced by 1 so the register can never sit at the
// all-zero lock-up state.
module puf_lfsr import puf_pkg::*; #(
  parameter int                  N_STAGES  = 16,
  parameter logic [N_STAGES-1:0] LFSR_TAPS = N_STAGES'(LFSR_TAPS_16)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [N_STAGES-1:0] seed,
  input  logic                step,
  output logic [N_STAGES-1:0] state
);

  logic [N_STAGES-1:0] state_q;
  logic [N_STAGES-1:0] state_d;

  // Next value: load has priority over step; otherwise hold.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed == '0) ? N_STAGES'(1) : seed;
    end else if (step) begin
      state_d = state_q[0] ? ((state_q >> 1) ^ LFSR_TAPS) : (state_q >> 1);
    end
  end

  // State register, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/arbiter_puf_ctrl.sv
// Controller for an N-stage arbiter PUF delay chain. Steps an LFSR through
// RESP_BITS challenges, runs N_VOTES arbiter-reset / launch / sample rounds
// per challenge, majority-votes the synchronized arbiter output and hands
// the assembled word out over a valid/ready handshake.
// Optional build macro: PUF_STABILITY_FLAG_EN adds resp_unstable, flagging
// challenges whose votes were not unanimous.
//
// Handshake: resp_data is offered while resp_valid is high and is held
// stable until a cycle with resp_valid && resp_ready, after which the
// controller returns to IDLE; resp_valid never drops without that transfer.
module arbiter_puf_ctrl import puf_pkg::*; #(
  parameter int                  N_STAGES      = 16,
  parameter int                  RESP_BITS     = 32,
  parameter int                  N_VOTES       = 7,
  parameter int                  SETTLE_CYCLES = 4,
  parameter logic [N_STAGES-1:0] LFSR_TAPS     = N_STAGES'(LFSR_TAPS_16)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N_STAGES-1:0]  seed,
  output logic                 busy,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [RESP_BITS-1:0] resp_data,
  output logic [N_STAGES-1:0]  puf_challenge,
  output logic                 puf_launch,
  output logic                 puf_arb_reset,
  input  logic                 puf_response
`ifdef PUF_STABILITY_FLAG_EN
  ,
  output logic [RESP_BITS-1:0] resp_unstable
`endif
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int VW = $clog2(N_VOTES + 1);
  localparam int BW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  localparam logic [CW-1:0] ARB_LAST    = CW'(ARB_RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [VW-1:0] VOTES_ALL   = VW'(N_VOTES);
  localparam logic [VW-1:0] MAJ_THR     = VW'(majority_threshold(N_VOTES));
  localparam logic [BW-1:0] BIT_LAST    = BW'(RESP_BITS - 1);

  puf_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [VW-1:0]       vote_q, vote_d;
  logic [VW-1:0]       ones_q, ones_d;
  logic [VW-1:0]       vote_inc;
  logic [BW-1:0]       bit_q, bit_d;
  logic [RESP_BITS-1:0] data_q, data_d;
  logic [1:0]          sync_q;
  logic                lfsr_load;
  logic                lfsr_step;
`ifdef PUF_STABILITY_FLAG_EN
  logic [RESP_BITS-1:0] unst_q, unst_d;
`endif

  // Challenge source; its state drives the delay chain directly and only
  // moves on load (IDLE) or step (COMMIT).
  puf_lfsr #(
    .N_STAGES  (N_STAGES),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (lfsr_step),
    .state (puf_challenge)
  );

  assign vote_inc = vote_q + VW'(1);

  // Next-state, counter updates and Moore outputs of the sequencing FSM.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    vote_d        = vote_q;
    ones_d        = ones_q;
    bit_d         = bit_q;
    data_d        = data_q;
    lfsr_load     = 1'b0;
    lfsr_step     = 1'b0;
    puf_arb_reset = 1'b0;
    puf_launch    = 1'b0;
    resp_valid    = 1'b0;
    busy          = (state_q != IDLE);
`ifdef PUF_STABILITY_FLAG_EN
    unst_d        = unst_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          lfsr_load = 1'b1;
          cnt_d     = '0;
          vote_d    = '0;
          ones_d    = '0;
          bit_d     = '0;
          data_d    = '0;
`ifdef PUF_STABILITY_FLAG_EN
          unst_d    = '0;
`endif
          state_d   = ARB_RST;
        end
      end
      ARB_RST: begin
        puf_arb_reset = 1'b1;
        if (cnt_q == ARB_LAST) begin
          cnt_d   = '0;
          state_d = LAUNCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LAUNCH: begin
        puf_launch = 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SAMPLE: begin
        puf_launch = 1'b1;
        ones_d     = ones_q + VW'(sync_q[1]);
        vote_d     = vote_inc;
        state_d    = (vote_inc == VOTES_ALL) ? COMMIT : ARB_RST;
      end
      COMMIT: begin
        data_d[bit_q] = (ones_q > MAJ_THR);
`ifdef PUF_STABILITY_FLAG_EN
        unst_d[bit_q] = (ones_q != '0) && (ones_q != VOTES_ALL);
`endif
        ones_d    = '0;
        vote_d    = '0;
        lfsr_step = 1'b1;
        if (bit_q == BIT_LAST) begin
          state_d = DONE;
        end else begin
          bit_d   = bit_q + BW'(1);
          state_d = ARB_RST;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, counters and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vote_q  <= '0;
      ones_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vote_q  <= vote_d;
      ones_q  <= ones_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
    end
  end

  // Two-flop synchronizer for the asynchronous arbiter output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], puf_response};
    end
  end

`ifdef PUF_STABILITY_FLAG_EN
  // Per-bit non-unanimity flags, same lifetime as the response word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      unst_q <= '0;
    end else begin
      unst_q <= unst_d;
    end
  end

  assign resp_unstable = unst_q;
`endif

  assign resp_data = data_q;

endmodule

// File: tb/tb_arbiter_puf_ctrl.sv
// Testbench for arbiter_puf_ctrl: a delay-chain stub answers each arbiter
// race from a vote table (or from challenge bit 0), and a reference model
// derives the challenge list and response word from the LFSR rule and the
// majority vote.
module tb_arbiter_puf_ctrl;

  localparam int          N_STAGES  = 16;
  localparam int          RESP_BITS = 32;
  localparam int          N_VOTES   = 7;
  localparam int          SETTLE    = 4;
  localparam int          LAT       = 1 + RESP_BITS * (N_VOTES * (SETTLE + 3) + 1);
  localparam logic [15:0] TAPS      = 16'hB400;

  // Stub modes
  localparam int M_ONES  = 0;
  localparam int M_PAT_A = 1;
  localparam int M_PAT_B = 2;
  localparam int M_CHAL  = 3;
  localparam int M_RAND  = 4;

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [N_STAGES-1:0]  seed;
  logic                 busy;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [RESP_BITS-1:0] resp_data;
  logic [N_STAGES-1:0]  puf_challenge;
  logic                 puf_launch;
  logic                 puf_arb_reset;
  logic                 puf_response;
`ifdef PUF_STABILITY_FLAG_EN
  logic [RESP_BITS-1:0] resp_unstable;
`endif

  arbiter_puf_ctrl #(
    .N_STAGES      (N_STAGES),
    .RESP_BITS     (RESP_BITS),
    .N_VOTES       (N_VOTES),
    .SETTLE_CYCLES (SETTLE),
    .LFSR_TAPS     (TAPS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .seed          (seed),
    .busy          (busy),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .puf_challenge (puf_challenge),
    .puf_launch    (puf_launch),
    .puf_arb_reset (puf_arb_reset),
    .puf_response  (puf_response)
`ifdef PUF_STABILITY_FLAG_EN
    ,
    .resp_unstable (resp_unstable)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- delay-chain stub ----------------
  int  stub_mode = M_ONES;
  bit  vote_tab[RESP_BITS*N_VOTES];
  int  vidx = 0;
  bit  arb_prev = 1'b0;

  initial begin
    puf_response = 1'b0;
    forever begin
      @(negedge clk);
      if (stub_mode == M_CHAL) begin
        puf_response = puf_challenge[0];
      end else if (puf_arb_reset && !arb_prev) begin
        // A new race starts: answer it with the next table entry.
        puf_response = vote_tab[vidx % (RESP_BITS*N_VOTES)];
        vidx++;
      end
      arb_prev = puf_arb_reset;
    end
  end

  // ---------------- reference model ----------------
  logic [RESP_BITS-1:0] exp_q[$];
  logic [RESP_BITS-1:0] exp_unst_q[$];
  logic [15:0]          exp_chal[RESP_BITS];
  logic [15:0]          obs_chal[RESP_BITS];
  int                   n_obs;

  function automatic logic [15:0] lfsr_next(input logic [15:0] c);
    if (c % 2 == 1) return (c >> 1) ^ TAPS;
    return c >> 1;
  endfunction

  task automatic fill_votes(input int mode);
    int pat_a[N_VOTES] = '{1, 1, 0, 1, 0, 0, 1};
    int pat_b[N_VOTES] = '{1, 0, 0, 1, 0, 0, 1};
    for (int b = 0; b < RESP_BITS; b++) begin
      for (int v = 0; v < N_VOTES; v++) begin
        case (mode)
          M_PAT_A: vote_tab[b*N_VOTES+v] = bit'(pat_a[v]);
          M_PAT_B: vote_tab[b*N_VOTES+v] = bit'(pat_b[v]);
          M_RAND:  vote_tab[b*N_VOTES+v] = bit'($urandom_range(0, 1));
          default: vote_tab[b*N_VOTES+v] = 1'b1;
        endcase
      end
    end
  endtask

  task automatic model_request(input logic [15:0] s, input int mode, input bit push);
    logic [15:0]          c;
    logic [RESP_BITS-1:0] word;
    logic [RESP_BITS-1:0] unst;
    int                   ones;
    c    = (s == 16'h0) ? 16'h1 : s;
    word = '0;
    unst = '0;
    for (int b = 0; b < RESP_BITS; b++) begin
      exp_chal[b] = c;
      ones = 0;
      for (int v = 0; v < N_VOTES; v++) begin
        if (mode == M_CHAL) ones += int'(c[0]);
        else                ones += int'(vote_tab[b*N_VOTES+v]);
      end
      word[b] = (2 * ones > N_VOTES);
      unst[b] = (ones != 0) && (ones != N_VOTES);
      c = lfsr_next(c);
    end
    if (push) begin
      exp_q.push_back(word);
      exp_unst_q.push_back(unst);
    end
  endtask

  // ---------------- driver: one full request ----------------
  task automatic run_request(input logic [15:0] s, input int mode, input bit busy_start,
                             input int hold_cycles, input bit ready_with_start);
    int                   cycles;
    int                   stab_err;
    int                   chal_err;
    int                   hold_err;
    bit                   act_prev;
    logic [15:0]          chal_prev;
    logic [RESP_BITS-1:0] got;
    logic [RESP_BITS-1:0] exp_word;
    logic [RESP_BITS-1:0] exp_unst;
    stub_mode = mode;
    fill_votes(mode);
    vidx = 0;
    model_request(s, mode, 1'b1);
    n_obs     = 0;
    stab_err  = 0;
    chal_err  = 0;
    act_prev  = 1'b0;
    chal_prev = '0;
    cycles    = 0;
    seed  = s;
    start = 1'b1;
    while (cycles < LAT + 100) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      cycles++;
      if (busy_start && cycles == 700) start = 1'b1;
      if ((puf_launch || puf_arb_reset) && act_prev && puf_challenge != chal_prev) stab_err++;
      if (puf_arb_reset && !act_prev) begin
        if (n_obs < RESP_BITS) obs_chal[n_obs] = puf_challenge;
        n_obs++;
      end
      act_prev  = puf_launch || puf_arb_reset;
      chal_prev = puf_challenge;
      if (resp_valid) break;
    end
    check_eq("latency", 64'(cycles), 64'(LAT));
    check_eq("busy_in_done", 64'(busy), 64'd1);
    exp_word = exp_q.pop_front();
    exp_unst = exp_unst_q.pop_front();
    got      = resp_data;
    check_eq("resp_data", 64'(resp_data), 64'(exp_word));
`ifdef PUF_STABILITY_FLAG_EN
    check_eq("resp_unstable", 64'(resp_unstable), 64'(exp_unst));
`else
    if (exp_unst === 'x) $display("unexpected X in model");
`endif
    check_eq("chal_count", 64'(n_obs), 64'(RESP_BITS));
    for (int b = 0; b < RESP_BITS && b < n_obs; b++) begin
      if (obs_chal[b] != exp_chal[b]) chal_err++;
    end
    check_eq("chal_sequence", 64'(chal_err), 64'd0);
    check_eq("chal_stable", 64'(stab_err), 64'd0);
    // Hold the word with resp_ready low.
    hold_err = 0;
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge clk);
      #1;
      if (!resp_valid || resp_data != got) hold_err++;
    end
    check_eq("hold_stable", 64'(hold_err), 64'd0);
    // Accept; optionally try to start in the same DONE cycle.
    resp_ready = 1'b1;
    start      = ready_with_start;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    start      = 1'b0;
    check_eq("busy_after_accept", 64'(busy), 64'd0);
    check_eq("valid_after_accept", 64'(resp_valid), 64'd0);
    check_eq("data_kept", 64'(resp_data), 64'(got));
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_stays_idle", 64'(busy), 64'd0);
  endtask

  // ---------------- reset in the middle of bit 5 ----------------
  task automatic run_reset_mid(input logic [15:0] s);
    int  cycles;
    int  rises;
    int  late;
    bit  arb_seen;
    bit  hit;
    stub_mode = M_RAND;
    fill_votes(M_RAND);
    vidx = 0;
    model_request(s, M_RAND, 1'b0);
    rises    = 0;
    arb_seen = 1'b0;
    hit      = 1'b0;
    cycles   = 0;
    seed  = s;
    start = 1'b1;
    while (cycles < LAT) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      cycles++;
      if (puf_arb_reset && !arb_seen) rises++;
      arb_seen = puf_arb_reset;
      if (rises == 5 * N_VOTES + 1 && puf_launch) begin
        hit = 1'b1;
        break;
      end
    end
    check_eq("reached_bit5_launch", 64'(hit), 64'd1);
    check_eq("bit5_challenge", 64'(puf_challenge), 64'(exp_chal[5]));
    reset = 1'b0;
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_data", 64'(resp_data), 64'd0);
    check_eq("rst_challenge", 64'(puf_challenge), 64'd0);
    check_eq("rst_launch", 64'(puf_launch), 64'd0);
    check_eq("rst_arb_reset", 64'(puf_arb_reset), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    late  = 0;
    for (int i = 0; i < LAT + 50; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid || busy) late++;
    end
    check_eq("no_resp_after_abort", 64'(late), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    seed       = '0;
    resp_ready = 1'b0;
    #1;
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_valid", 64'(resp_valid), 64'd0);
    check_eq("reset_data", 64'(resp_data), 64'd0);
    check_eq("reset_challenge", 64'(puf_challenge), 64'd0);
    check_eq("reset_launch", 64'(puf_launch), 64'd0);
    check_eq("reset_arb_reset", 64'(puf_arb_reset), 64'd0);
`ifdef PUF_STABILITY_FLAG_EN
    check_eq("reset_unstable", 64'(resp_unstable), 64'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    // Stray resp_ready in IDLE does nothing.
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check_eq("ready_in_idle", 64'(busy), 64'd0);

    // Constant-one arbiter, start pulse during busy, 50-cycle hold.
    run_request(16'h0001, M_ONES, 1'b1, 50, 1'b0);
    check_eq("all_ones_word", 64'(resp_data), 64'hFFFF_FFFF);
    // 4-of-7 and 3-of-7 vote patterns.
    run_request(16'h1234, M_PAT_A, 1'b0, 2, 1'b1);
    check_eq("pat_a_word", 64'(resp_data), 64'hFFFF_FFFF);
    run_request(16'hBEEF, M_PAT_B, 1'b0, 2, 1'b0);
    check_eq("pat_b_word", 64'(resp_data), 64'h0);
    // Zero seed and challenge-tied arbiter.
    run_request(16'h0000, M_CHAL, 1'b0, 1, 1'b1);
    check_eq("first_challenge", 64'(obs_chal[0]), 64'h0001);
    check_eq("second_challenge", 64'(obs_chal[1]), 64'hB400);
    // Randomized seeds and votes.
    for (int r = 0; r < 3; r++) begin
      run_request(16'($urandom_range(0, 16'hFFFF)), M_RAND, 1'b0,
                  $urandom_range(0, 5), bit'($urandom_range(0, 1)));
    end
    run_request(16'($urandom_range(1, 16'hFFFF)), M_CHAL, 1'b0, 1, 1'b0);
    // Abort mid-run, then a clean full request.
    run_reset_mid(16'($urandom_range(0, 16'hFFFF)));
    run_request(16'($urandom_range(0, 16'hFFFF)), M_RAND, 1'b0, 3, 1'b0);

    check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arbiter_puf_ctrl.md
Name: arbiter_puf_ctrl

Overview:
- Parametrised controller for an N-stage arbiter PUF delay chain.
- The delay chain and its arbiter flop stay a separate hard macro: MUX chain plus DFF, all dont_touch.
- Generates a challenge sequence from a seeded LFSR and sequences arbiter-reset, launch and sample.
- Majority-votes repeated evaluations per challenge and assembles a RESP_BITS-wide response word for the AES key path, delivered over a valid/ready handshake.

Parameters:
- N_STAGES, 16, challenge width (delay-chain stages).
- RESP_BITS, 32, response bits per request (one challenge per bit).
- N_VOTES, 7, evaluations per challenge; odd, >=1.
- SETTLE_CYCLES, 4, launch-high cycles before sampling; >=3.
- LFSR_TAPS, 16'hB400, Galois feedback mask, N_STAGES wide.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- seed  in  N_STAGES  initial challenge, captured on accepted start.
- busy  out  1  high from accepted start until response accepted.
- resp_valid  out  1  response word available.
- resp_ready  in  1  consumer accepts the word.
- resp_data  out  RESP_BITS  response; bit i is from challenge i.
- puf_challenge  out  N_STAGES  to delay chain; held stable outside IDLE.
- puf_launch  out  1  rising edge launches both races.
- puf_arb_reset  out  1  clears the arbiter flop (drives its reset).
- puf_response  in  1  arbiter output; asynchronous, passes a 2-FF synchronizer inside.

Behaviour:
- Reset (reset=0), asynchronous, all outputs low:
  - state=IDLE; busy=0, resp_valid=0, resp_data=0, puf_challenge=0, puf_launch=0, puf_arb_reset=0.
  - Counters and synchronizer cleared.
  - Reset mid-operation aborts without emitting a response.
- FSM states: IDLE, ARB_RST, LAUNCH, SAMPLE, COMMIT, DONE.
- IDLE:
  - start=1 captures the seed into the LFSR; a seed of 0 is replaced by 1.
  - Clears bit index, vote index and ones counter; sets busy=1; goes to ARB_RST.
  - start=0 stays in IDLE.
- ARB_RST: 2 cycles, puf_arb_reset=1, puf_launch=0 -> LAUNCH.
- LAUNCH: SETTLE_CYCLES cycles, puf_launch=1, puf_arb_reset=0 -> SAMPLE.
- SAMPLE: 1 cycle, puf_launch=1.
  - ones += synchronized response; vote index += 1.
  - If vote index reaches N_VOTES -> COMMIT, else -> ARB_RST.
- COMMIT: 1 cycle.
  - resp_data[bit]=(ones > N_VOTES/2); ones and vote index cleared.
  - LFSR advances one Galois step; puf_challenge takes the new value.
  - Last bit -> DONE, else bit += 1 -> ARB_RST.
- DONE:
  - resp_valid=1; resp_data held stable.
  - resp_ready=1 -> IDLE next cycle, with resp_valid=0 and busy=0. resp_data keeps its value until the next start.
- Latency, start to resp_valid: 1 + RESP_BITS*(N_VOTES*(SETTLE_CYCLES+3)+1) cycles. Default: 1 + 32*(7*7+1) = 1601.
- Boundary conditions:
  - start while busy is ignored.
  - start and resp_ready in the same DONE cycle: the start is ignored.
  - resp_ready outside DONE has no effect.
  - The ones counter is sized to $clog2(N_VOTES+1) and cannot wrap.
  - The LFSR never reaches 0.

Optional Feature:
- Macro: PUF_STABILITY_FLAG_EN.
- Defined: adds output resp_unstable[RESP_BITS-1:0].
  - Bit i=1 when the votes for challenge i were not unanimous (ones not 0 and not N_VOTES).
  - Same reset, valid and hold rules as resp_data.
- Undefined: port absent, no extra flops.

Decomposition:
- Package puf_pkg:
  - FSM state enum.
  - ARB_RST_CYCLES=2.
  - Default LFSR_TAPS constant for 16 stages.
  - Function for the majority threshold.
- Sub-module puf_lfsr (N_STAGES, LFSR_TAPS):
  - Inputs: clk, reset, load, seed, step. Output: state.
  - Zero-seed substitution done inside.

Test Plan:
- Stub drives puf_response=1 constantly, seed=16'h0001, start -> resp_valid exactly 1601 cycles after start; resp_data=32'hFFFFFFFF.
- Stub returns the vote pattern 1,1,0,1,0,0,1 per challenge (4 ones) -> every bit=1. Pattern 1,0,0,1,0,0,1 (3 ones) -> every bit=0. With PUF_STABILITY_FLAG_EN, both cases give resp_unstable=32'hFFFFFFFF.
- Challenge sequence: seed=16'h0000 -> first puf_challenge=16'h0001, second=16'hB400. puf_challenge never changes during ARB_RST, LAUNCH or SAMPLE.
- Handshake: hold resp_ready=0 for 50 cycles in DONE -> resp_valid and resp_data stable. Raise resp_ready -> busy=0 next cycle. A start pulsed during busy is ignored.
- Reset mid-operation: assert reset during LAUNCH of bit 5 -> all outputs 0 immediately, no resp_valid afterwards. A new start runs the full 1601-cycle sequence.
- Stub response tied to challenge[0] -> resp_data bit i equals bit 0 of the challenge-i LFSR value, matching a reference-model LFSR.
